// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   Packs instruction fields into 16-bit words and queues them in a 4-entry
//   FIFO. Each word leaves with an 8-bit instruction-memory address. The
//   address counter advances by one on every pop and wraps from 8'hFF to
//   8'h00.
//
//   Word layout:
//     [15:14] cond
//     [13:10] opcode
//     [9:7]   dest
//     [6:0]   load        when opcode == 4'hF
//     [6:0]   {src1, src2, 1'b0} for every other opcode
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : field set on in_* is valid this cycle
//   in_ready   : FIFO has room (count < 4); driven only from registered state
//   in_cond    : 2-bit condition code
//   in_opcode  : 4-bit opcode
//   in_dest    : 3-bit destination register
//   in_src1    : 3-bit source register 1
//   in_src2    : 3-bit source register 2
//   in_load    : 7-bit load/shift immediate
//   out_valid  : out_instr/out_addr hold a word (count != 0)
//   out_ready  : consumer takes the head word this cycle
//   out_instr  : oldest unpopped word; reads 16'h0000 while the FIFO is empty
//   out_addr   : instruction-memory address for out_instr
//   count      : FIFO occupancy, 0..4
// ---------------------------------------------------------------------------
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_cond,
  input  logic [3:0]  in_opcode,
  input  logic [2:0]  in_dest,
  input  logic [2:0]  in_src1,
  input  logic [2:0]  in_src2,
  input  logic [6:0]  in_load,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic [7:0]  out_addr,
  output logic [2:0]  count
);

  // Build one encoded word. Only the fields the opcode uses can reach the
  // output: src1/src2 are dropped for the load opcode, and load is dropped
  // for every other opcode.
  function automatic logic [15:0] encode_word(
    input logic [1:0] cond,
    input logic [3:0] opcode,
    input logic [2:0] dest,
    input logic [2:0] src1,
    input logic [2:0] src2,
    input logic [6:0] load
  );
    logic [15:0] word;
    word[15:14] = cond;
    word[13:10] = opcode;
    word[9:7]   = dest;
    if (opcode == 4'hF) begin
      word[6:0] = load;
    end else begin
      word[6:0] = {src1, src2, 1'b0};
    end
    return word;
  endfunction

  logic [15:0] mem_q [4];
  logic [15:0] mem_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q,  count_d;
  logic [7:0]  addr_q,   addr_d;
  logic        push_s;
  logic        pop_s;
  logic [15:0] enc_word_s;

  // Handshake flags and outputs, all derived from registered state.
  always_comb begin
    in_ready   = (count_q < 3'd4);
    out_valid  = (count_q != 3'd0);
    push_s     = in_valid && in_ready;
    pop_s      = out_valid && out_ready;
    enc_word_s = encode_word(in_cond, in_opcode, in_dest, in_src1, in_src2, in_load);
    count      = count_q;
    out_addr   = addr_q;
    // Gate the head entry so an empty FIFO never shows a stale word.
    if (out_valid) begin
      out_instr = mem_q[rd_ptr_q];
    end else begin
      out_instr = 16'h0000;
    end
  end

  // Next-state logic for the storage, pointers, occupancy and address.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    addr_d   = addr_q;

    if (push_s) begin
      mem_d[wr_ptr_q] = enc_word_s;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
      addr_d   = addr_q + 8'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
      addr_d   = addr_q;
    end

    // A push and a pop in the same cycle cancel out in the occupancy.
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset wins over any push or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= 16'h0000;
      end
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      addr_q   <= 8'h00;
    end else begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//   Directed bench for instr_encoder. Inputs change and outputs are sampled
//   on the falling clock edge; the DUT updates on the rising edge.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_cond;
  logic [3:0]  in_opcode;
  logic [2:0]  in_dest;
  logic [2:0]  in_src1;
  logic [2:0]  in_src2;
  logic [6:0]  in_load;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [7:0]  out_addr;
  logic [2:0]  count;

  int total;
  int bad;

  instr_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cond   (in_cond),
    .in_opcode (in_opcode),
    .in_dest   (in_dest),
    .in_src1   (in_src1),
    .in_src2   (in_src2),
    .in_load   (in_load),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle on the following falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic v, input logic [1:0] c, input logic [3:0] op,
                        input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2,
                        input logic [6:0] ld);
    in_valid  = v;
    in_cond   = c;
    in_opcode = op;
    in_dest   = d;
    in_src1   = s1;
    in_src2   = s2;
    in_load   = ld;
  endtask

  task automatic idle_in();
    set_in(1'b0, 2'd0, 4'd0, 3'd0, 3'd0, 3'd0, 7'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, {13'd0, count}, 16'd0);
    check({tag, "_ovalid"}, {15'd0, out_valid}, 16'd0);
    check({tag, "_iready"}, {15'd0, in_ready}, 16'd1);
    check({tag, "_addr"}, {8'd0, out_addr}, 16'h0000);
    check({tag, "_instr"}, out_instr, 16'h0000);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    out_ready = 1'b0;
    idle_in();
    @(negedge clk);
    cyc();
    cyc();
    check_reset_state("reset");

    // First edge with rst low accepts a push; load field ignored for opcode 3.
    rst = 1'b0;
    set_in(1'b1, 2'b10, 4'h3, 3'd5, 3'd2, 3'd7, 7'h7F);
    cyc();
    idle_in();
    check("enc_valid", {15'd0, out_valid}, 16'd1);
    check("enc_instr", out_instr, 16'h8EAE);
    check("enc_addr", {8'd0, out_addr}, 16'h0000);
    check("enc_count", {13'd0, count}, 16'd1);

    // Held while out_ready is low.
    cyc();
    check("hold_instr", out_instr, 16'h8EAE);
    check("hold_addr", {8'd0, out_addr}, 16'h0000);

    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("pop1_count", {13'd0, count}, 16'd0);
    check("pop1_valid", {15'd0, out_valid}, 16'd0);
    check("pop1_addr", {8'd0, out_addr}, 16'h0001);

    // Empty: out_ready must not move the address.
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("empty_addr", {8'd0, out_addr}, 16'h0001);
    check("empty_count", {13'd0, count}, 16'd0);

    // Load opcode: src fields randomised, must not matter.
    set_in(1'b1, 2'b01, 4'hF, 3'd1, 3'($urandom_range(7)), 3'($urandom_range(7)), 7'h55);
    cyc();
    idle_in();
    check("load_instr", out_instr, 16'h7CD5);
    check("load_addr", {8'd0, out_addr}, 16'h0001);

    // Full test from a clean reset.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_reset_state("reset2");
    for (int k = 1; k <= 5; k++) begin
      set_in(1'b1, 2'd0, 4'(k), 3'(k), 3'd0, 3'd0, 7'd0);
      cyc();
      if (k == 4) begin
        check("full_count4", {13'd0, count}, 16'd4);
        check("full_iready4", {15'd0, in_ready}, 16'd0);
      end
    end
    check("full_count5", {13'd0, count}, 16'd4);
    check("full_head", out_instr, 16'h0480);
    // Full with out_ready high: pop only, the offered word is dropped.
    out_ready = 1'b1;
    cyc();
    idle_in();
    check("fullpop_count", {13'd0, count}, 16'd3);
    check("fullpop_head", out_instr, 16'h0900);
    check("fullpop_addr", {8'd0, out_addr}, 16'h0001);
    cyc();
    check("drain2_head", out_instr, 16'h0D80);
    check("drain2_addr", {8'd0, out_addr}, 16'h0002);
    cyc();
    check("drain3_head", out_instr, 16'h1200);
    check("drain3_addr", {8'd0, out_addr}, 16'h0003);
    cyc();
    out_ready = 1'b0;
    check("drain_count", {13'd0, count}, 16'd0);
    check("drain_valid", {15'd0, out_valid}, 16'd0);
    check("drain_addr", {8'd0, out_addr}, 16'h0004);

    // Simultaneous push and pop at count 2.
    set_in(1'b1, 2'b11, 4'h2, 3'd3, 3'd4, 3'd5, 7'd0);
    cyc();
    set_in(1'b1, 2'b00, 4'hF, 3'd7, 3'd0, 3'd0, 7'h7F);
    cyc();
    check("sim_pre_count", {13'd0, count}, 16'd2);
    check("sim_pre_head", out_instr, 16'hC9CA);
    set_in(1'b1, 2'b10, 4'h1, 3'd0, 3'd7, 3'd1, 7'd0);
    out_ready = 1'b1;
    cyc();
    idle_in();
    check("sim_count", {13'd0, count}, 16'd2);
    check("sim_head", out_instr, 16'h3FFF);
    check("sim_addr", {8'd0, out_addr}, 16'h0005);
    cyc();
    check("sim_next", out_instr, 16'h8472);
    check("sim_next_addr", {8'd0, out_addr}, 16'h0006);
    cyc();
    out_ready = 1'b0;
    check("sim_empty", {13'd0, count}, 16'd0);

    // Address wrap: 256 pops from address 0.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      set_in(1'b1, 2'd0, 4'h1, 3'd2, 3'd3, 3'd4, 7'd0);
      cyc();
      idle_in();
      if (i == 255) begin
        check("wrap_addr_ff", {8'd0, out_addr}, 16'h00FF);
      end
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
    end
    set_in(1'b1, 2'd0, 4'h1, 3'd2, 3'd3, 3'd4, 7'd0);
    cyc();
    idle_in();
    check("wrap_addr_00", {8'd0, out_addr}, 16'h0000);
    check("wrap_instr", out_instr, 16'h0538);

    // Reset mid-stream with count 3 and push/pop requested at the reset edge.
    set_in(1'b1, 2'b11, 4'h7, 3'd6, 3'd1, 3'd1, 7'd0);
    cyc();
    cyc();
    check("mid_count", {13'd0, count}, 16'd3);
    rst = 1'b1;
    out_ready = 1'b1;
    cyc();
    rst = 1'b0;
    idle_in();
    out_ready = 1'b0;
    check_reset_state("midrst");
    out_ready = 1'b1;
    cyc();
    check("midrst_nostale", {15'd0, out_valid}, 16'd0);
    check("midrst_addr2", {8'd0, out_addr}, 16'h0000);
    out_ready = 1'b0;
    set_in(1'b1, 2'b01, 4'hF, 3'd1, 3'd0, 3'd0, 7'h55);
    cyc();
    idle_in();
    check("midrst_fresh", out_instr, 16'h7CD5);
    check("midrst_fresh_cnt", {13'd0, count}, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 Port rst, input, 1: synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 Port in_valid, input, 1: field set on in_* ports is valid this cycle.
REQ-004 Port in_ready, output, 1: encoder can accept a field set this cycle.
REQ-005 Port in_cond, input, 2: condition code field.
REQ-006 Port in_opcode, input, 4: opcode field.
REQ-007 Port in_dest, input, 3: destination register.
REQ-008 Port in_src1, input, 3: source register 1.
REQ-009 Port in_src2, input, 3: source register 2.
REQ-010 Port in_load, input, 7: load/shift immediate.
REQ-011 Port out_valid, output, 1: out_instr/out_addr hold a valid encoded word.
REQ-012 Port out_ready, input, 1: consumer accepts the word this cycle.
REQ-013 Port out_instr, output, 16: encoded instruction at FIFO head.
REQ-014 Port out_addr, output, 8: instruction-memory address for out_instr.
REQ-015 Port count, output, 3: FIFO occupancy, 0..4.

Function
REQ-016 Encoding SHALL be: [15:14]=cond, [13:10]=opcode, [9:7]=dest, then [6:0]=in_load when opcode==4'hF, else [6:4]=src1, [3:1]=src2, [0]=0 — the exact inverse of the team instruction decoder field split.
REQ-017 Unused fields (src1/src2 for opcode 4'hF; in_load otherwise) SHALL have no effect on out_instr.
REQ-018 Push: in_valid && in_ready at edge N SHALL write the encoded word into a 4-entry FIFO at edge N.
REQ-019 Latency: word pushed into an empty FIFO at edge N SHALL appear with out_valid=1 in the cycle after edge N (no same-cycle bypass).
REQ-020 in_ready SHALL equal (count<4) and depend only on registered state (no combinational path from out_ready).
REQ-021 Pop: out_valid && out_ready at edge N SHALL remove the head word and increment the address counter by 1 at edge N.
REQ-022 out_valid SHALL equal (count!=0); out_instr SHALL be the oldest unpopped word; words SHALL exit in push order.
REQ-023 out_instr/out_addr SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 Simultaneous push and pop in one cycle SHALL leave count unchanged and preserve order.
REQ-025 Full (count=4): push SHALL NOT occur even if out_ready=1 that cycle; pop proceeds normally.
REQ-026 Empty (count=0): out_ready ignored; address counter unchanged.
REQ-027 Address counter SHALL wrap 8'hFF -> 8'h00 on pop.
REQ-028 Read/write pointers SHALL be 2-bit and wrap 3 -> 0.
REQ-029 in_valid with in_ready=0 SHALL be ignored (no side effects).

Reset
REQ-030 rst=1 at an edge SHALL set count=0, out_valid=0, in_ready=1, out_addr=8'h00, pointers=0; out_instr SHALL read 16'h0000.
REQ-031 rst SHALL take priority over simultaneous push/pop; FIFO contents are discarded mid-operation.
REQ-032 First push is accepted on the first edge with rst=0.

Verification
REQ-033 Encode: cond=2'b10, opcode=4'h3, dest=5, src1=2, src2=7 pushed into empty FIFO -> next cycle out_valid=1, out_instr=16'h8EAE, out_addr=8'h00.
REQ-034 Load: cond=2'b01, opcode=4'hF, dest=1, load=7'h55, src1/src2 random -> out_instr=16'h7CD5.
REQ-035 Full: out_ready=0, push 5 words back-to-back -> count=4, in_ready=0 after fourth, fifth not accepted; drain -> four words in order, out_addr 0,1,2,3.
REQ-036 Simultaneous: count=2, push and pop same cycle -> count stays 2, order preserved, out_addr increments by 1.
REQ-037 Wrap: 256 pops -> out_addr returns to 8'h00 on the 257th word.
REQ-038 Reset mid-stream: count=3, assert rst one cycle -> count=0, out_valid=0, out_addr=0, in_ready=1; stale words never emitted.
